// File: rtl/modred_mont_iter.sv
// Iterative word-serial Montgomery reduction: R = T * 2^(-W) mod q.
// Reduces L bits of the 2W-bit product per cycle over N = W/L iterations.
// A single conditional subtraction follows the iterations.
// Optional build macro MODRED_LAZY_EN drops the final subtraction.
// In that build the result lies in [0, 2q) and the latency is N edges.
module modred_mont_iter #(
  parameter int W = 60,
  parameter int L = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   T_in,
  input  logic [W-1:0]     q,
  input  logic [L-1:0]     qp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     R
);

  localparam int N  = W / L;
  localparam int CW = $clog2(N + 1);
  localparam int AW = 2 * W + 1;

`ifdef MODRED_LAZY_EN
  typedef enum logic [1:0] {IDLE, RED, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RED, SUB, DONE} state_t;
`endif

  state_t          state, state_next;
  logic [AW-1:0]   acc, acc_next;
  logic [W-1:0]    q_reg;
  logic [L-1:0]    qp_reg;
  logic [L-1:0]    m;
  logic [L+W-1:0]  mq;
  logic [CW-1:0]   cnt;
  logic            last_iter;
  logic            load, iter, finish, release_out;
`ifndef MODRED_LAZY_EN
  logic            ge;
  logic [W-1:0]    r_sub;
`endif

  // One reduction step: clear the low L bits by adding m*q, then shift them out
  always_comb begin
    m         = acc[L-1:0] * qp_reg;
    mq        = {{W{1'b0}}, m} * {{L{1'b0}}, q_reg};
    acc_next  = (acc + {{(AW-L-W){1'b0}}, mq}) >> L;
    last_iter = (cnt == CW'(N - 1));
  end

`ifndef MODRED_LAZY_EN
  // Final conditional subtraction; acc < 2q here, so the low W bits suffice
  always_comb begin
    ge    = (acc >= {{(AW-W){1'b0}}, q_reg});
    r_sub = ge ? (acc[W-1:0] - q_reg) : acc[W-1:0];
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and datapath strobes
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    load        = 1'b0;
    iter        = 1'b0;
    finish      = 1'b0;
    release_out = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = RED;
        end
      end
      RED: begin
        iter = 1'b1;
        if (last_iter) begin
`ifdef MODRED_LAZY_EN
          finish     = 1'b1;
          state_next = DONE;
`else
          state_next = SUB;
`endif
        end
      end
`ifndef MODRED_LAZY_EN
      SUB: begin
        finish     = 1'b1;
        state_next = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          release_out = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: operand capture, accumulator, counter and result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      q_reg     <= '0;
      qp_reg    <= '0;
      cnt       <= '0;
      R         <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        acc    <= {1'b0, T_in};
        q_reg  <= q;
        qp_reg <= qp;
        cnt    <= '0;
      end else if (iter) begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
      end
      if (finish) begin
`ifdef MODRED_LAZY_EN
        R <= acc_next[W-1:0];
`else
        R <= r_sub;
`endif
        out_valid <= 1'b1;
      end
      if (release_out) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modred_mont_iter.sv
// Directed bench for modred_mont_iter at W=60, L=20, q=2^59+1, qp=0xFFFFF.
module tb_modred_mont_iter;

  localparam int W = 60;
  localparam int L = 20;
`ifdef MODRED_LAZY_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 4;
`endif
  localparam logic [W-1:0] Q  = 60'h800000000000001;
  localparam logic [L-1:0] QP = 20'hFFFFF;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] t_in;
  logic [W-1:0]   q_in;
  logic [L-1:0]   qp_in;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   r_out;

  int total = 0;
  int bad   = 0;

  modred_mont_iter #(.W(W), .L(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .T_in(t_in), .q(q_in), .qp(qp_in), .out_valid(out_valid),
    .out_ready(out_ready), .R(r_out)
  );

  always #5 clk = ~clk;

  // Drive one operand set, wait for its result; inputs are scrambled after accept
  task automatic run_op(input logic [2*W-1:0] t, output logic [W-1:0] r,
                        output int lat, output bit busy_rdy);
    int waitc;
    busy_rdy = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; t_in = t; q_in = Q; qp_in = QP;
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; t_in = ~t; q_in = ~Q; qp_in = 20'h12345;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      if (in_ready !== 1'b0) busy_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready !== 1'b0) busy_rdy = 1'b1;
    r = r_out;
    if (out_ready && out_valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    t_in = '0; q_in = '0; qp_in = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (r_out !== '0) begin bad++; $display("FAIL reset_R: got %h want 0", r_out); end
    rst = 1'b0;
  endtask

  task automatic test_zero();
    logic [W-1:0] r; int lat; bit busy;
    run_op('0, r, lat, busy);
    total++; if (r !== '0) begin bad++; $display("FAIL zero_R: got %h want 0", r); end
    total++; if (lat != LAT) begin bad++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
    total++; if (busy) begin bad++; $display("FAIL zero_in_ready_busy: in_ready high during operation, want 0"); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_release: out_valid=%b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL zero_idle: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_mont_one();
    logic [2*W-1:0] tv [6];
    logic [W-1:0]   ev [6];
    logic [W-1:0]   r; int lat; bit busy;
    tv[0] = 120'd1 << 60;                         // 2^60
    tv[1] = 120'd1 << 119;                        // (q-1)*2^60
    tv[2] = {60'd1, Q};                           // q + 2^60: acc ends at q+1
    tv[3] = {60'd0, Q};                           // q: acc ends exactly at q
    tv[4] = {Q, 60'd0} - {60'd0, Q};              // q*(2^60-1): acc ends at q
    tv[5] = 120'd1 << 118;                        // (2^59)^2 -> 2^58
    ev[0] = 60'd1;
    ev[1] = 60'd1 << 59;
    ev[5] = 60'd1 << 58;
`ifdef MODRED_LAZY_EN
    ev[2] = Q + 60'd1;
    ev[3] = Q;
    ev[4] = Q;
`else
    ev[2] = 60'd1;
    ev[3] = 60'd0;
    ev[4] = 60'd0;
`endif
    for (int i = 0; i < 6; i++) begin
      run_op(tv[i], r, lat, busy);
      total++; if (r !== ev[i]) begin bad++; $display("FAIL mont_one[%0d]_R: got %h want %h", i, r, ev[i]); end
      total++; if (lat != LAT) begin bad++; $display("FAIL mont_one[%0d]_latency: got %0d want %0d", i, lat, LAT); end
      total++; if (busy) begin bad++; $display("FAIL mont_one[%0d]_in_ready_busy: high during operation, want 0", i); end
    end
  endtask

  task automatic test_random();
    logic [63:0]    tmp;
    logic [2*W-1:0] a, b, t;
    logic [180:0]   lhs, rhs, qx, bound;
    logic [W-1:0]   r; int lat; bit busy;
    qx = {121'd0, Q};
`ifdef MODRED_LAZY_EN
    bound = qx << 1;
`else
    bound = qx;
`endif
    for (int i = 0; i < 30; i++) begin
      tmp = {$urandom(), $urandom()};
      a = {61'd0, tmp[58:0]};
      tmp = {$urandom(), $urandom()};
      b = {61'd0, tmp[58:0]};
      if (i == 0) a = {60'd0, Q - 60'd1};
      t = a * b;
      run_op(t, r, lat, busy);
      lhs = ({121'd0, r} << 60) % qx;
      rhs = {61'd0, t} % qx;
      total++; if (lhs !== rhs) begin bad++; $display("FAIL random[%0d]_congruence: T=%h R=%h R*2^60 mod q=%h want %h", i, t, r, lhs, rhs); end
      total++; if ({121'd0, r} >= bound) begin bad++; $display("FAIL random[%0d]_range: R=%h not below %h", i, r, bound); end
      total++; if (lat != LAT) begin bad++; $display("FAIL random[%0d]_latency: got %0d want %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] r; int lat; bit busy;
    out_ready = 1'b0;
    run_op(120'd1 << 119, r, lat, busy);
    total++; if (r !== (60'd1 << 59)) begin bad++; $display("FAIL bp_R: got %h want %h", r, 60'd1 << 59); end
    total++; if (lat != LAT) begin bad++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
    @(negedge clk);
    in_valid = 1'b1; t_in = 120'd1 << 60; q_in = Q; qp_in = QP;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_valid); end
      total++; if (r_out !== (60'd1 << 59)) begin bad++; $display("FAIL bp_hold_R[%0d]: got %h want %h", c, r_out, 60'd1 << 59); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    run_op(120'd1 << 60, r, lat, busy);
    total++; if (r !== 60'd1) begin bad++; $display("FAIL bp_next_R: got %h want 1", r); end
    total++; if (lat != LAT) begin bad++; $display("FAIL bp_next_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r; int lat; bit busy; bit spurious;
    int waitc;
    @(negedge clk);
    in_valid = 1'b1; t_in = {60'd1, Q}; q_in = Q; qp_in = QP;
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 100) begin @(negedge clk); waitc++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    total++; if (r_out !== '0) begin bad++; $display("FAIL rstmid_R: got %h want 0", r_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    spurious = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) spurious = 1'b1;
    end
    total++; if (spurious) begin bad++; $display("FAIL rstmid_spurious: out_valid=1 seen after abort, want 0"); end
    run_op(120'd1 << 60, r, lat, busy);
    total++; if (r !== 60'd1) begin bad++; $display("FAIL rstmid_next_R: got %h want 1", r); end
    total++; if (lat != LAT) begin bad++; $display("FAIL rstmid_next_latency: got %0d want %0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_mont_one();
    test_random();
    test_back_pressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

endmodule
